// File: rtl/alm_dot_acc.sv
// Streaming saturating dot-product accumulator fed by the approximate log multiplier.
// Products arrive over valid/ready; one signed result per programmed vector length is returned.
module alm_dot_acc #(
  parameter int PW     = 32,
  parameter int AW     = 40,
  parameter int LEN_W  = 8,
  parameter int OC_FIX = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 prod_valid_i,
  output logic                 prod_ready_o,
  input  logic [PW-1:0]        prod_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic signed [AW-1:0] res_o,
  output logic                 sat_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    res_q, res_d;
  logic             sat_q, sat_d;
  logic             res_sat_q, res_sat_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic             beat;
  logic             oc_bit;
  logic [AW:0]      opnd;
  logic [AW:0]      sum;
  logic             ovf;
  logic [AW-1:0]    sum_sat;

  assign beat   = prod_valid_i && (state_q == S_ACC);
  // Ones'-complement negatives are off by one; the +1 rides in as a carry on the sign-extended operand.
  assign oc_bit = (OC_FIX != 0) && prod_i[PW-1];
  assign opnd   = {{(AW+1-PW){prod_i[PW-1]}}, prod_i} + {{AW{1'b0}}, oc_bit};
  assign sum    = {acc_q[AW-1], acc_q} + opnd;
  assign ovf    = sum[AW] ^ sum[AW-1];
  assign sum_sat = !ovf    ? sum[AW-1:0] :
                   sum[AW] ? {1'b1, {(AW-1){1'b0}}} :
                             {1'b0, {(AW-1){1'b1}}};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_sat_d = res_sat_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            cnt_d   = len_i;
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = S_ACC;
          end else begin
            res_d     = '0;
            res_sat_d = 1'b0;
            state_d   = S_HOLD;
          end
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d = sum_sat;
          sat_d = sat_q | ovf;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            res_d     = sum_sat;
            res_sat_d = sat_q | ovf;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_sat_q <= res_sat_d;
    end
  end

  assign prod_ready_o = (state_q == S_ACC);
  assign res_valid_o  = (state_q == S_HOLD);
  assign busy_o       = (state_q != S_IDLE);
  assign res_o        = res_q;
  assign sat_o        = res_sat_q;

endmodule

// File: tb/tb_alm_dot_acc.sv
// Bench for alm_dot_acc: three parameterisations share one stimulus stream and are checked every
// cycle against an arithmetic model, plus literal expectations from hand-worked vectors.
module tb_alm_dot_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, pv, rr;
  logic [7:0]  len;
  logic [31:0] prod;

  logic        pr [3];
  logic        rv [3];
  logic        bz [3];
  logic        st [3];
  logic [39:0] r0;
  logic [33:0] r1, r2;

  alm_dot_acc #(.PW(32), .AW(40), .LEN_W(8), .OC_FIX(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .prod_valid_i(pv),
    .prod_ready_o(pr[0]), .prod_i(prod), .res_valid_o(rv[0]), .res_ready_i(rr),
    .res_o(r0), .sat_o(st[0]), .busy_o(bz[0]));
  alm_dot_acc #(.PW(32), .AW(34), .LEN_W(8), .OC_FIX(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .prod_valid_i(pv),
    .prod_ready_o(pr[1]), .prod_i(prod), .res_valid_o(rv[1]), .res_ready_i(rr),
    .res_o(r1), .sat_o(st[1]), .busy_o(bz[1]));
  alm_dot_acc #(.PW(32), .AW(34), .LEN_W(8), .OC_FIX(0)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .prod_valid_i(pv),
    .prod_ready_o(pr[2]), .prod_i(prod), .res_valid_o(rv[2]), .res_ready_i(rr),
    .res_o(r2), .sat_o(st[2]), .busy_o(bz[2]));

  int checks = 0;
  int failures = 0;

  int aw [3] = '{40, 34, 34};
  int oc [3] = '{1, 1, 0};

  // Behavioural model: phase 0 idle, 1 collecting products, 2 result waiting.
  int     m_phase;
  int     m_left;
  longint m_acc [3];
  bit     m_sat [3];
  longint m_res [3];
  bit     m_rsat [3];
  bit     started = 1'b0;

  function automatic longint mask(int w);
    return (64'sd1 <<< w) - 1;
  endfunction

  function automatic longint dut_res(int k);
    case (k)
      0: return longint'({24'd0, r0});
      1: return longint'({30'd0, r1});
      default: return longint'({30'd0, r2});
    endcase
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0; m_sat[k] = 0; m_res[k] = 0; m_rsat[k] = 0;
      end
    end else begin
      case (m_phase)
        0: if (start) begin
          if (len != 0) begin
            m_left = int'(len);
            for (int k = 0; k < 3; k++) begin m_acc[k] = 0; m_sat[k] = 0; end
            m_phase = 1;
          end else begin
            for (int k = 0; k < 3; k++) begin m_res[k] = 0; m_rsat[k] = 0; end
            m_phase = 2;
          end
        end
        1: if (pv) begin
          for (int k = 0; k < 3; k++) begin
            longint v, s, hi, lo;
            v  = longint'($signed(prod)) + ((oc[k] != 0 && prod[31]) ? 1 : 0);
            hi = (64'sd1 <<< (aw[k] - 1)) - 1;
            lo = -(64'sd1 <<< (aw[k] - 1));
            s  = m_acc[k] + v;
            if (s > hi) begin s = hi; m_sat[k] = 1; end
            else if (s < lo) begin s = lo; m_sat[k] = 1; end
            m_acc[k] = s;
          end
          m_left--;
          if (m_left == 0) begin
            for (int k = 0; k < 3; k++) begin m_res[k] = m_acc[k]; m_rsat[k] = m_sat[k]; end
            m_phase = 2;
          end
        end
        default: if (rr) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("prod_ready[%0d]", k), longint'(pr[k]), longint'(m_phase == 1));
        chk($sformatf("res_valid[%0d]", k),  longint'(rv[k]), longint'(m_phase == 2));
        chk($sformatf("busy[%0d]", k),       longint'(bz[k]), longint'(m_phase != 0));
        chk($sformatf("res[%0d]", k),        dut_res(k), m_res[k] & mask(aw[k]));
        chk($sformatf("sat[%0d]", k),        longint'(st[k]), longint'(m_rsat[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input int l);
    start = 1'b1; len = 8'(l);
    tick();
    start = 1'b0; len = 8'd0;
  endtask

  task automatic beat(input logic [31:0] p);
    pv = 1'b1; prod = p;
    tick();
    pv = 1'b0; prod = 32'd0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50 && rv[0] !== 1'b1; i++) tick();
    chk({name, "_valid_seen"}, longint'(rv[0]), 1);
  endtask

  task automatic handshake();
    rr = 1'b1;
    tick();
    rr = 1'b0;
    chk("idle_after_hs", longint'(bz[0]), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pv = 1'b0; rr = 1'b0; len = 8'd0; prod = 32'd0;
    tick(); tick();
    chk("rst_res", dut_res(0), 0);
    chk("rst_ready", longint'(pr[0]), 0);
    rst_n = 1'b1;
    tick();

    // Basic: 100 + 200 + (-50)
    start_vec(3);
    beat(32'd100); beat(32'd200); beat(32'hFFFF_FFCD);
    chk("basic_latency", longint'(rv[0]), 1);
    chk("basic_res", dut_res(0), 250);
    chk("basic_sat", longint'(st[0]), 0);
    handshake();
    tick();

    // Gaps between beats and result backpressure: 7 + (-10) = -3
    start_vec(2);
    beat(32'd7);
    tick(); tick(); tick();
    beat(32'hFFFF_FFF5);
    for (int i = 0; i < 5; i++) begin
      chk("gap_res_stable", dut_res(0), 40'hFF_FFFF_FFFD);
      chk("gap_valid_held", longint'(rv[0]), 1);
      tick();
    end
    handshake();
    tick();

    // Positive saturation at AW=34
    start_vec(5);
    for (int i = 0; i < 5; i++) beat(32'h7FFF_FFFF);
    wait_valid("satp");
    chk("satp_res", dut_res(1), 34'h1_FFFF_FFFF);
    chk("satp_sat", longint'(st[1]), 1);
    chk("satp_wide_nosat", longint'(st[0]), 0);
    handshake();
    tick();

    // Negative saturation, OC_FIX=0
    start_vec(5);
    for (int i = 0; i < 5; i++) beat(32'h8000_0000);
    wait_valid("satn");
    chk("satn_res", dut_res(2), 34'h2_0000_0000);
    chk("satn_sat", longint'(st[2]), 1);
    handshake();
    tick();

    // Zero-length vector
    start_vec(0);
    chk("zero_valid", longint'(rv[0]), 1);
    chk("zero_ready", longint'(pr[0]), 0);
    chk("zero_res", dut_res(0), 0);
    handshake();
    tick();

    // Reset mid-vector, then start ignored outside IDLE
    start_vec(4);
    beat(32'd5); beat(32'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", longint'(bz[0]), 0);
    chk("midrst_res", dut_res(0), 0);
    tick();
    start_vec(1);
    start = 1'b1; len = 8'd3;
    beat(32'd9);
    chk("rst_new_res", dut_res(0), 9);
    tick();
    rr = 1'b1;
    tick();
    rr = 1'b0; start = 1'b0; len = 8'd0;
    chk("start_in_hold_ignored", longint'(bz[0]), 0);
    tick();

    // No correction when OC_FIX=0
    start_vec(1);
    beat(32'hFFFF_FFFF);
    chk("oc0_res", dut_res(2), 34'h3_FFFF_FFFF);
    chk("oc1_res", dut_res(0), 0);
    handshake();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alm_dot_acc.md
Name: alm_dot_acc

Overview:
- Streaming dot-product accumulator placed directly downstream of the 16x16 approximate logarithmic multiplier.
- Consumes its 32-bit signed products one per handshake.
- Converts the multiplier's ones'-complement negative encoding to two's complement.
- Accumulates a programmed number of products with saturation and returns one result per vector over a valid/ready interface.

Parameters:
- PW, 32: product input width.
- AW, 40: accumulator/result width; must be > PW.
- LEN_W, 8: width of the vector-length field.
- OC_FIX, 1: when 1, add 1 to every product whose MSB is set (ones'- to two's-complement correction); when 0, products are used as-is.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  start pulse; sampled only in IDLE.
- len_i  in  LEN_W  number of products in the vector; latched on an accepted start.
- prod_valid_i  in  1  product valid from the multiplier stage.
- prod_ready_o  out  1  accumulator ready for a product.
- prod_i  in  PW  product, signed, ones'-complement negatives when OC_FIX=1.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  downstream accepts result.
- res_o  out  AW  signed accumulated result.
- sat_o  out  1  result saturated; qualified by res_valid_o.
- busy_o  out  1  high in ACC and HOLD.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE; acc, count, res_o, sat_o cleared to 0.
  - prod_ready_o=0, res_valid_o=0, busy_o=0.
  - Reset mid-ACC or mid-HOLD abandons the vector; no result is produced.
- IDLE:
  - prod_ready_o=0.
  - start_i=1 and len_i!=0: latch count=len_i, acc=0, sat=0, go to ACC.
  - start_i=1 and len_i==0: go to HOLD with res_o=0, sat_o=0; res_valid_o rises the next cycle.
- ACC:
  - prod_ready_o=1 (combinational from state only; no dependency on prod_valid_i).
  - Each cycle with prod_valid_i & prod_ready_o is one beat.
  - Per beat, operand = sign-extend(prod_i) to AW+1 bits, plus (OC_FIX & prod_i[PW-1]) as carry-in.
  - Sum = acc + operand, computed in AW+1 bits.
  - If sum overflows the signed AW range, clamp to 2^(AW-1)-1 or -2^(AW-1) and set the sticky sat flag. Clamped acc remains the base for subsequent beats.
  - count decrements per beat.
  - Beat with count==1: acc/sat update is registered into res_o/sat_o in the same edge, then go to HOLD.
  - Latency: res_valid_o=1 on the cycle immediately after the last beat.
  - Cycles without prod_valid_i hold all state.
  - start_i is ignored in ACC.
- HOLD:
  - res_valid_o=1; prod_ready_o=0.
  - res_o and sat_o are stable until res_ready_i=1.
  - On the handshake, go to IDLE; res_valid_o=0 next cycle.
  - start_i in HOLD, including the handshake cycle, is ignored; a new vector needs start_i in IDLE, giving a minimum one-cycle gap.
- res_o is not cleared on leaving HOLD; it holds the last value until the next result.
- Width rules: LEN_W-bit count gives up to 2^LEN_W-1 products per vector.
- Zero products from the multiplier are 0 for either sign; no correction is applied since the MSB is 0.

Test Plan:
- Basic, OC_FIX=1: start len=3; beats 100, 200, 32'hFFFFFFCD (ones'-complement -50) -> res_valid_o the cycle after beat 3, res_o=250, sat_o=0.
- Gaps and backpressure: len=2; prod_valid_i toggled with 3 idle cycles between beats 7 and 32'hFFFFFFF5 (-10); res_ready_i held low 5 cycles -> res_o=-3 stable throughout; IDLE the cycle after res_ready_i=1.
- Saturation, AW=34: len=5 of 32'h7FFFFFFF -> res_o=34'h1_FFFF_FFFF, sat_o=1. Repeat with 5 x 32'h80000000 (OC_FIX=0) -> res_o=34'h2_0000_0000, sat_o=1.
- Zero length: start with len_i=0 -> prod_ready_o never high, res_valid_o high the next cycle with res_o=0, sat_o=0.
- Reset mid-operation: len=4, 2 beats, then rst_ni=0 one cycle -> all outputs 0; start_i asserted in ACC/HOLD has no effect; a new len=1 vector with beat 9 -> res_o=9.
- OC_FIX=0 regression: len=1, prod 32'hFFFFFFFF -> res_o=-1 (no correction).
